// File: rtl/imm_gen_pipe.sv
// Registered RV32I/RV64I immediate generator with a 2-entry skid buffer.
// Optional pc+imm target path is enabled by defining IMM_GEN_PC_ADD_EN.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
`ifdef IMM_GEN_PC_ADD_EN
  input  logic [XLEN-1:0]  in_pc,
  output logic [XLEN-1:0]  out_target,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_JLR = 7'b1100111;
  localparam logic [6:0] OP_SYS = 7'b1110011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             ill;
    logic [TAG_W-1:0] tag;
`ifdef IMM_GEN_PC_ADD_EN
    logic [XLEN-1:0]  tgt;
`endif
  } ent_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  ent_t       dec;
  logic [6:0] opc;
  logic [2:0] f3;

  assign opc = in_instr[6:0];
  assign f3  = in_instr[14:12];

  always_comb begin
    dec     = '0;
    dec.tag = in_tag;
    unique case (opc)
      OP_IMM: begin
        if (f3 == 3'b001 || f3 == 3'b101) begin
          dec.fmt = FMT_SHAMT;
          if (XLEN == 64) dec.imm[5:0] = in_instr[25:20];
          else            dec.imm[4:0] = in_instr[24:20];
        end else begin
          dec.fmt = FMT_I;
          dec.imm = sext32({{20{in_instr[31]}}, in_instr[31:20]});
        end
      end
      OP_LD, OP_JLR, OP_SYS: begin
        dec.fmt = FMT_I;
        dec.imm = sext32({{20{in_instr[31]}}, in_instr[31:20]});
      end
      OP_ST: begin
        dec.fmt = FMT_S;
        dec.imm = sext32({{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]});
      end
      OP_BR: begin
        dec.fmt = FMT_B;
        dec.imm = sext32({{19{in_instr[31]}}, in_instr[31], in_instr[7],
                          in_instr[30:25], in_instr[11:8], 1'b0});
      end
      OP_LUI, OP_AUI: begin
        dec.fmt = FMT_U;
        dec.imm = sext32({in_instr[31:12], 12'b0});
      end
      OP_JAL: begin
        dec.fmt = FMT_J;
        dec.imm = sext32({{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                          in_instr[20], in_instr[30:21], 1'b0});
      end
      default: dec.ill = 1'b1;
    endcase
`ifdef IMM_GEN_PC_ADD_EN
    // Target is formed before buffering so the pc need not be stored separately.
    if (dec.fmt == FMT_B || dec.fmt == FMT_J || opc == OP_AUI)
      dec.tgt = in_pc + dec.imm;
`endif
  end

  occ_t occ_q, occ_d;
  ent_t out_q, skid_q;
  logic rdy_q;
  logic accept, pop;
  logic ld_out_in, ld_out_skid, ld_skid;

  assign accept = in_valid & rdy_q;
  assign pop    = (occ_q != EMPTY) & out_ready;

  always_comb begin
    occ_d       = occ_q;
    ld_out_in   = 1'b0;
    ld_out_skid = 1'b0;
    ld_skid     = 1'b0;
    if (flush) begin
      occ_d = EMPTY;
    end else begin
      unique case (occ_q)
        EMPTY: if (accept) begin
          occ_d     = ONE;
          ld_out_in = 1'b1;
        end
        ONE: begin
          if (accept && !pop) begin
            occ_d   = FULL;
            ld_skid = 1'b1;
          end else if (!accept && pop) begin
            occ_d = EMPTY;
          end else if (accept && pop) begin
            ld_out_in = 1'b1;
          end
        end
        FULL: if (pop) begin
          occ_d       = ONE;
          ld_out_skid = 1'b1;
        end
        default: occ_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q  <= EMPTY;
      rdy_q  <= 1'b1;
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      occ_q <= occ_d;
      // Registered ready keeps out_ready off the in_ready timing path.
      rdy_q <= (occ_d != FULL);
      if (ld_out_in)        out_q <= dec;
      else if (ld_out_skid) out_q <= skid_q;
      if (ld_skid)          skid_q <= dec;
    end
  end

  assign in_ready    = rdy_q;
  assign out_valid   = (occ_q != EMPTY);
  assign out_imm     = out_q.imm;
  assign out_fmt     = out_q.fmt;
  assign out_illegal = out_q.ill;
  assign out_tag     = out_q.tag;
`ifdef IMM_GEN_PC_ADD_EN
  assign out_target  = out_q.tgt;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus and
// are checked against a queue-based reference model of the spec rules.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [4:0]  in_tag;
  logic [63:0] pc;
  logic        rdy32, rdy64, vld32, vld64, ill32, ill64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [2:0]  fmt32, fmt64;
  logic [4:0]  tag32, tag64;
`ifdef IMM_GEN_PC_ADD_EN
  logic [31:0] tgt32;
  logic [63:0] tgt64;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(5)) u32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_tag(in_tag),
`ifdef IMM_GEN_PC_ADD_EN
    .in_pc(pc[31:0]), .out_target(tgt32),
`endif
    .out_valid(vld32), .out_ready(out_ready), .out_imm(imm32), .out_fmt(fmt32),
    .out_illegal(ill32), .out_tag(tag32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(5)) u64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_tag(in_tag),
`ifdef IMM_GEN_PC_ADD_EN
    .in_pc(pc), .out_target(tgt64),
`endif
    .out_valid(vld64), .out_ready(out_ready), .out_imm(imm64), .out_fmt(fmt64),
    .out_illegal(ill64), .out_tag(tag64)
  );

  typedef struct {
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  fmt;
    logic        ill;
    logic [4:0]  tag;
    logic [31:0] t32;
    logic [63:0] t64;
  } exp_t;

  exp_t q[$];

  function automatic exp_t model(input logic [31:0] ins, input logic [4:0] tg,
                                 input logic [63:0] p);
    exp_t e;
    longint s;
    logic signed [11:0] i12;
    logic signed [12:0] b13;
    logic signed [19:0] u20;
    logic signed [20:0] j21;
    bit   sx;
    e = '{imm32: 0, imm64: 0, fmt: 0, ill: 0, tag: tg, t32: 0, t64: 0};
    s = 0;
    sx = 1'b1;
    i12 = ins[31:20];
    case (ins[6:0])
      7'h13: begin
        if (ins[13:12] == 2'b01) begin
          e.fmt = 6; sx = 1'b0;
          e.imm32 = {27'b0, ins[24:20]};
          e.imm64 = {58'b0, ins[25:20]};
        end else begin
          e.fmt = 1; s = i12;
        end
      end
      7'h03, 7'h67, 7'h73: begin e.fmt = 1; s = i12; end
      7'h23: begin i12 = {ins[31:25], ins[11:7]}; e.fmt = 2; s = i12; end
      7'h63: begin
        b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        e.fmt = 3; s = b13;
      end
      7'h37, 7'h17: begin u20 = ins[31:12]; e.fmt = 4; s = u20; s = s * 4096; end
      7'h6F: begin
        j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        e.fmt = 5; s = j21;
      end
      default: begin e.ill = 1'b1; sx = 1'b0; end
    endcase
    if (sx) begin
      e.imm64 = s;
      e.imm32 = e.imm64[31:0];
    end
    if (e.fmt == 3 || e.fmt == 5 || ins[6:0] == 7'h17) begin
      e.t64 = p + e.imm64;
      e.t32 = p[31:0] + e.imm32;
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] o, input logic [63:0] x);
    checks++;
    assert (o === x) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", nm, o, x);
    end
  endtask

  task automatic check_state();
    chk("rdy32", {63'b0, rdy32}, {63'b0, q.size() < 2});
    chk("rdy64", {63'b0, rdy64}, {63'b0, q.size() < 2});
    chk("vld32", {63'b0, vld32}, {63'b0, q.size() > 0});
    chk("vld64", {63'b0, vld64}, {63'b0, q.size() > 0});
    if (q.size() > 0) begin
      chk("imm32", {32'b0, imm32}, {32'b0, q[0].imm32});
      chk("imm64", imm64, q[0].imm64);
      chk("fmt32", {61'b0, fmt32}, {61'b0, q[0].fmt});
      chk("fmt64", {61'b0, fmt64}, {61'b0, q[0].fmt});
      chk("ill", {62'b0, ill32, ill64}, {62'b0, q[0].ill, q[0].ill});
      chk("tag", {54'b0, tag32, tag64}, {54'b0, q[0].tag, q[0].tag});
`ifdef IMM_GEN_PC_ADD_EN
      chk("tgt32", {32'b0, tgt32}, {32'b0, q[0].t32});
      chk("tgt64", tgt64, q[0].t64);
`endif
    end
  endtask

  // One clock: check at negedge, drive, then update the model after posedge.
  task automatic cyc(input bit v, input logic [31:0] ins, input bit ordy, input bit fl,
                     input logic [63:0] p, output bit acc);
    exp_t e;
    bit   pp;
    @(negedge clk);
    check_state();
    in_valid  = v;
    in_instr  = ins;
    in_tag    = 5'($urandom);
    pc        = p;
    out_ready = ordy;
    flush     = fl;
    acc = v && (q.size() < 2) && !fl;
    pp  = (q.size() > 0) && ordy;
    e   = model(ins, in_tag, p);
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
  endtask

  task automatic expect_head(input string nm, input logic [31:0] i32, input logic [63:0] i64,
                             input logic [2:0] f, input logic il);
    #1;
    chk({nm, "_imm32"}, {32'b0, imm32}, {32'b0, i32});
    chk({nm, "_imm64"}, imm64, i64);
    chk({nm, "_fmt"}, {61'b0, fmt32}, {61'b0, f});
    chk({nm, "_ill"}, {63'b0, ill32}, {63'b0, il});
  endtask

  function automatic logic [63:0] rpc();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [31:0] rinstr();
    logic [6:0]  ops [12];
    logic [31:0] r;
    ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F, 7'h33, 7'h0F};
    r = $urandom;
    r[6:0] = ops[$urandom_range(0, 11)];
    return r;
  endfunction

  initial begin
    bit          a;
    int          idx, k;
    logic [31:0] strm [4];
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_tag = '0; pc = '0;
    #12;
    chk("rst_rdy", {62'b0, rdy32, rdy64}, 64'd3);
    chk("rst_vld", {62'b0, vld32, vld64}, 64'd0);
    chk("rst_imm", imm64 | {32'b0, imm32}, 64'd0);
    chk("rst_fmt_ill_tag", {52'b0, fmt32, fmt64, ill32, ill64, tag32}, 64'd0);
    @(negedge clk); rst = 1'b0;

    cyc(1, 32'hFFF00093, 1, 0, rpc(), a);
    expect_head("addi", 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 3'd1, 1'b0);
    cyc(1, 32'h01F09093, 1, 0, rpc(), a);
    expect_head("slli31", 32'h1F, 64'h1F, 3'd6, 1'b0);
    cyc(1, 32'h03F09093, 1, 0, rpc(), a);
    expect_head("slli63", 32'h1F, 64'h3F, 3'd6, 1'b0);
    cyc(1, 32'hFFDFF06F, 1, 0, rpc(), a);
    expect_head("jal", 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 3'd5, 1'b0);
    cyc(1, 32'h123450B7, 1, 0, rpc(), a);
    expect_head("lui", 32'h12345000, 64'h12345000, 3'd4, 1'b0);
    cyc(1, 32'h0000007F, 1, 0, rpc(), a);
    expect_head("illegal", 32'h0, 64'h0, 3'd0, 1'b1);
    cyc(1, 32'h00000863, 1, 0, 64'hFFFFFFFF_FFFFFFF8, a);
    expect_head("beq16", 32'h10, 64'h10, 3'd3, 1'b0);
`ifdef IMM_GEN_PC_ADD_EN
    chk("wrap32", {32'b0, tgt32}, 64'h8);
    chk("wrap64", tgt64, 64'h8);
`endif
    cyc(0, 0, 1, 0, rpc(), a);

    // Four-instruction stream with the consumer stalled for three cycles.
    for (int i = 0; i < 4; i++) strm[i] = rinstr();
    idx = 0;
    for (k = 0; k < 20 && (idx < 4 || q.size() > 0); k++) begin
      cyc(idx < 4, strm[idx % 4], k >= 3, 0, rpc(), a);
      if (a) idx++;
      if (k == 1) begin
        #1;
        chk("stall_rdy", {62'b0, rdy32, rdy64}, 64'd0);
      end
    end
    chk("stream_done", {59'b0, idx[4:0]}, 64'd4);

    // Flush while FULL with a valid input in the same cycle.
    cyc(1, rinstr(), 0, 0, rpc(), a);
    cyc(1, rinstr(), 0, 0, rpc(), a);
    cyc(1, 32'h00100093, 1, 1, rpc(), a);
    #1;
    chk("flush_vld", {62'b0, vld32, vld64}, 64'd0);
    chk("flush_rdy", {62'b0, rdy32, rdy64}, 64'd3);
    cyc(0, 0, 1, 0, rpc(), a);
    cyc(0, 0, 1, 0, rpc(), a);

    // Asynchronous reset while FULL.
    cyc(1, rinstr(), 0, 0, rpc(), a);
    cyc(1, rinstr(), 0, 0, rpc(), a);
    #2;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_vld", {62'b0, vld32, vld64}, 64'd0);
    chk("arst_rdy", {62'b0, rdy32, rdy64}, 64'd3);
    q.delete();
    @(negedge clk); rst = 1'b0;
    cyc(0, 0, 1, 0, rpc(), a);

    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) != 0, rinstr(), ($urandom % 3) != 0,
          ($urandom % 25) == 0, rpc(), a);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, rpc(), a);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
